// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - instruction prefetch queue between fetch and decode
//
// Issues word-aligned fetch requests from fetch_pc, parks each request in a
// circular queue slot, fills slots as in-order responses return and presents
// the head slot to decode. A redirect flushes the queue and restarts fetch;
// responses still outstanding at that moment are counted off and discarded.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   imem_req_*              fetch request (valid/ready handshake, addr)
//   imem_rsp_*              in-order instruction return (no backpressure)
//   redirect_valid/_pc      branch/jump redirect from execute
//   dec_*                   head entry to decode (valid/ready, instr, pc, pc+4)
//   occupancy               reserved queue entries, for debug
module fetch_prefetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     imem_req_valid,
  output logic [XLEN-1:0]          imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [31:0]              dec_instr,
  output logic [XLEN-1:0]          dec_pc,
  output logic [XLEN-1:0]          dec_pc_plus4,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] fetchPc;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   fillPtr;      // oldest reserved entry still waiting for data
  logic [CW-1:0]   reserved;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   dropCnt;      // responses still owed to pre-redirect requests
  logic [XLEN-1:0] entryPc    [DEPTH];
  logic [31:0]     entryInstr [DEPTH];
  logic [DEPTH-1:0] entryFilled;

  logic            reqFire;
  logic            popFire;
  logic            rspSeen;
  logic            rspDrop;
  logic            rspWrite;
  logic [CW-1:0]   inflightNext;
  logic            unusedRedirectLsbs;

  always_comb begin
    imem_req_valid = reset && !redirect_valid && (reserved < FULL) && (inflight < FULL);
    dec_valid      = entryFilled[head] && !redirect_valid;
    reqFire        = imem_req_valid && imem_req_ready;
    popFire        = dec_valid && dec_ready;
    // A response with nothing outstanding (e.g. left over from before a reset)
    // is ignored entirely.
    rspSeen        = imem_rsp_valid && (inflight != '0);
    rspDrop        = rspSeen && (dropCnt != '0);
    rspWrite       = rspSeen && (dropCnt == '0) && !redirect_valid;
    inflightNext   = inflight + CW'(reqFire) - CW'(rspSeen);
  end

  assign imem_req_addr      = fetchPc;
  assign dec_instr          = entryInstr[head];
  assign dec_pc             = entryPc[head];
  // Held at zero while in reset so every decode output shows its reset value.
  assign dec_pc_plus4       = reset ? (dec_pc + XLEN'(4)) : '0;
  assign occupancy          = reserved;
  assign unusedRedirectLsbs = ^redirect_pc[1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetchPc     <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      fillPtr     <= '0;
      reserved    <= '0;
      inflight    <= '0;
      dropCnt     <= '0;
      entryFilled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entryPc[i]    <= '0;
        entryInstr[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Everything still outstanding after this edge belongs to the old path.
      fetchPc     <= {redirect_pc[XLEN-1:2], 2'b00};
      head        <= '0;
      tail        <= '0;
      fillPtr     <= '0;
      reserved    <= '0;
      inflight    <= inflightNext;
      dropCnt     <= inflightNext;
      entryFilled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entryPc[i]    <= '0;
        entryInstr[i] <= '0;
      end
    end else begin
      inflight <= inflightNext;
      dropCnt  <= dropCnt - CW'(rspDrop);
      reserved <= reserved + CW'(reqFire) - CW'(popFire);
      // tail, fillPtr and head always address distinct slots when active.
      if (reqFire) begin
        entryPc[tail]     <= fetchPc;
        entryFilled[tail] <= 1'b0;
        tail              <= tail + PW'(1);
        fetchPc           <= fetchPc + XLEN'(4);
      end
      if (rspWrite) begin
        entryInstr[fillPtr]  <= imem_rsp_data;
        entryFilled[fillPtr] <= 1'b1;
        fillPtr              <= fillPtr + PW'(1);
      end
      // Clearing on pop keeps an emptied queue from showing a stale filled head.
      if (popFire) begin
        entryFilled[head] <= 1'b0;
        head              <= head + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - self-checking bench for fetch_prefetch_queue
module tb_fetch_prefetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus4;
  logic [2:0]  occupancy;

  fetch_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .dec_pc_plus4(dec_pc_plus4), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  // Memory model: every accepted request is tagged with the redirect epoch and
  // reset generation it was issued in, and returned memLat cycles later.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          gen;
    int          due;
  } memReq_t;

  memReq_t     memQ[$];
  memReq_t     curRsp;
  logic        rspPresent = 1'b0;
  int          memLat = 1;
  int          epoch  = 0;
  int          gen    = 0;
  int          cyc    = 0;
  int          nCmp   = 0;
  int          nFail  = 0;

  // Decode-side model: PCs decode must see in order, and how many of them
  // (counted from the front) already have their instruction.
  logic [31:0] mFetchPc = RESET_PC;
  logic [31:0] mPcQ[$];
  int          mFilled = 0;

  function automatic logic [31:0] instrOf(logic [31:0] a);
    return a ^ 32'hCAFE_0013;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic memDrive();
    if (memQ.size() > 0 && memQ[0].due <= cyc) begin
      curRsp         = memQ.pop_front();
      rspPresent     = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instrOf(curRsp.addr);
    end else begin
      rspPresent     = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
    memDrive();
  endtask

  always @(negedge clock) begin : cmpProc
    int   outstanding;
    logic expReq;
    logic expDec;
    logic accept;
    logic pop;
    if (!reset) begin
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_req_addr", imem_req_addr, RESET_PC);
      check("rst_dec_valid", dec_valid, 0);
      check("rst_occupancy", occupancy, 0);
      check("rst_dec_instr", dec_instr, 0);
      check("rst_dec_pc", dec_pc, 0);
      check("rst_dec_pc_plus4", dec_pc_plus4, 0);
      mFetchPc = RESET_PC;
      mPcQ.delete();
      mFilled = 0;
      gen++;
    end else begin
      outstanding = 0;
      foreach (memQ[i]) if (memQ[i].gen == gen) outstanding++;
      if (rspPresent && curRsp.gen == gen) outstanding++;
      expReq = !redirect_valid && (mPcQ.size() < DEPTH) && (outstanding < DEPTH);
      expDec = (mFilled > 0) && !redirect_valid;
      check("req_valid", imem_req_valid, expReq);
      check("req_addr", imem_req_addr, mFetchPc);
      check("dec_valid", dec_valid, expDec);
      check("occupancy", occupancy, mPcQ.size());
      if (expDec && dec_valid) begin
        check("dec_pc", dec_pc, mPcQ[0]);
        check("dec_instr", dec_instr, instrOf(mPcQ[0]));
        check("dec_pc_plus4", dec_pc_plus4, mPcQ[0] + 32'd4);
      end
      accept = expReq && imem_req_ready;
      pop    = expDec && dec_ready;
      if (redirect_valid) begin
        mPcQ.delete();
        mFilled  = 0;
        mFetchPc = {redirect_pc[31:2], 2'b00};
        epoch++;
      end else begin
        if (pop) begin
          void'(mPcQ.pop_front());
          mFilled--;
        end
        if (rspPresent && curRsp.gen == gen && curRsp.epoch == epoch) mFilled++;
        if (accept) begin
          mPcQ.push_back(mFetchPc);
          memQ.push_back('{mFetchPc, epoch, gen, cyc + memLat});
          mFetchPc += 32'd4;
        end
      end
    end
    cyc++;
  end

  task automatic drain();
    imem_req_ready = 1'b0;
    dec_ready      = 1'b1;
    for (int i = 0; i < 40; i++) begin
      nextCycle();
      if (memQ.size() == 0 && !rspPresent && mPcQ.size() == 0) break;
    end
    #2;
    check("drain_occupancy", occupancy, 0);
  endtask

  task automatic waitDecValid(string name, logic [31:0] expPc);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      #2;
      if (dec_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_seen"}, seen, 1);
    if (seen) check(name, dec_pc, expPc);
  endtask

  initial begin
    reset          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b1;
    repeat (3) nextCycle();

    // Streaming from reset with zero-wait memory.
    reset = 1'b1;
    #2;
    check("first_req_valid", imem_req_valid, 1);
    check("first_req_addr", imem_req_addr, 32'h0);
    nextCycle(); #2;
    check("c1_dec_valid", dec_valid, 0);
    nextCycle(); #2;
    check("c2_dec_valid", dec_valid, 1);
    check("c2_dec_pc", dec_pc, 32'h0);
    nextCycle(); #2;
    check("c3_dec_pc", dec_pc, 32'h4);
    check("c3_dec_instr", dec_instr, 32'hCAFE_0017);
    check("c3_dec_pc_plus4", dec_pc_plus4, 32'h8);
    repeat (10) nextCycle();

    // Decode stall fills the queue, then resumes.
    dec_ready = 1'b0;
    repeat (8) nextCycle();
    #2;
    check("full_occupancy", occupancy, 4);
    check("full_req_valid", imem_req_valid, 0);
    dec_ready = 1'b1;
    repeat (12) nextCycle();

    // Misaligned redirect with exactly two requests in flight, latency 3.
    drain();
    memLat         = 3;
    imem_req_ready = 1'b1;
    nextCycle();
    nextCycle();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    imem_req_ready = 1'b1;
    #2;
    check("redir_req_valid", imem_req_valid, 0);
    check("redir_dec_valid", dec_valid, 0);
    nextCycle();
    redirect_valid = 1'b0;
    #2;
    check("redir_req_addr", imem_req_addr, 32'h100);
    check("redir_req_valid_after", imem_req_valid, 1);
    waitDecValid("redir_first_pc", 32'h100);
    check("redir_first_instr", dec_instr, 32'hCAFE_0113);

    // Redirect coincident with a response and a would-be pop.
    memLat = 1;
    repeat (10) nextCycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #2;
    check("coinc_dec_valid", dec_valid, 0);
    nextCycle();
    redirect_valid = 1'b0;
    #2;
    check("coinc_req_addr", imem_req_addr, 32'h200);
    check("coinc_occupancy", occupancy, 0);
    repeat (8) nextCycle();

    // Back-to-back redirects while responses are being dropped.
    memLat = 3;
    repeat (6) nextCycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    nextCycle();
    redirect_pc    = 32'h400;
    nextCycle();
    redirect_valid = 1'b0;
    #2;
    check("b2b_req_addr", imem_req_addr, 32'h400);
    repeat (2) nextCycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h502;
    nextCycle();
    redirect_valid = 1'b0;
    waitDecValid("b2b_first_pc", 32'h500);
    repeat (15) nextCycle();

    // Reset with three entries reserved and two responses in flight.
    drain();
    dec_ready      = 1'b0;
    memLat         = 2;
    imem_req_ready = 1'b1;
    nextCycle();
    nextCycle();
    nextCycle();
    imem_req_ready = 1'b0;
    check("pre_rst_occupancy", occupancy, 3);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_occupancy", occupancy, 0);
    check("mid_rst_dec_valid", dec_valid, 0);
    check("mid_rst_req_valid", imem_req_valid, 0);
    nextCycle();
    reset = 1'b1;
    #2;
    check("post_rst_req_valid", imem_req_valid, 1);
    check("post_rst_req_addr", imem_req_addr, RESET_PC);
    nextCycle();
    nextCycle();
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    waitDecValid("post_rst_first_pc", RESET_PC);
    repeat (6) nextCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish within time limit");
    $fatal(1);
  end

endmodule
